// File: rtl/nor_flash_ctrl.sv
// Host-side NOR flash controller: READ, PROGRAM (read-modify-write AND) and SECTOR_ERASE.
// Optional program-verify readback is enabled with `define NOR_FLASH_PROGRAM_VERIFY_EN.
module nor_flash_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int SECTOR_W = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_PG_RD,
        S_PG_WAIT,
        S_PG_WR,
        S_ER_WR,
`ifdef NOR_FLASH_PROGRAM_VERIFY_EN
        S_VF_RD,
        S_VF_WAIT,
`endif
        S_RESP
    } state_e;

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [SECTOR_W-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic [1:0]            wait_q, wait_d;
    logic                  err_q, err_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
    logic [DATA_W-1:0]     mem_data_in_q, mem_data_in_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

    assign cnt_nxt = cnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        wait_d        = wait_q;
        err_d         = err_q;
        mem_we_d      = 1'b0;
        mem_re_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        rsp_rdata_d   = rsp_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wdata_d = cmd_wdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    wait_d  = '0;
                    unique case (cmd_op)
                        2'b00: begin
                            state_d       = S_RD_ISSUE;
                            mem_re_d      = 1'b1;
                            mem_address_d = cmd_addr;
                        end
                        2'b01: begin
                            state_d       = S_PG_RD;
                            mem_re_d      = 1'b1;
                            mem_address_d = cmd_addr;
                        end
                        2'b10: begin
                            state_d       = S_ER_WR;
                            mem_we_d      = 1'b1;
                            mem_address_d = {cmd_addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b0}}};
                            mem_data_in_d = {DATA_W{1'b1}};
                        end
                        default: begin
                            state_d     = S_RESP;
                            err_d       = 1'b1;
                            rsp_rdata_d = '0;
                        end
                    endcase
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    rsp_rdata_d = mem_data_out;
                    state_d     = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_PG_RD: state_d = S_PG_WAIT;
            S_PG_WAIT: begin
                // Program can only clear bits; flag any attempt to raise one.
                if (wait_q == LAT_LAST) begin
                    mem_data_in_d = mem_data_out & wdata_q;
                    err_d         = |(~mem_data_out & wdata_q);
                    mem_we_d      = 1'b1;
                    state_d       = S_PG_WR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
`ifdef NOR_FLASH_PROGRAM_VERIFY_EN
            S_PG_WR: begin
                state_d  = S_VF_RD;
                mem_re_d = 1'b1;
                wait_d   = '0;
            end
            S_VF_RD: state_d = S_VF_WAIT;
            S_VF_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    rsp_rdata_d = mem_data_out;
                    err_d       = err_q | (mem_data_out != mem_data_in_q);
                    state_d     = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
`else
            S_PG_WR: state_d = S_RESP;
`endif
            S_ER_WR: begin
                // Only the in-sector bits advance, so the top sector never wraps to address 0.
                if (cnt_q == '1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d         = cnt_nxt;
                    mem_we_d      = 1'b1;
                    mem_address_d = {mem_address_q[ADDR_W-1:SECTOR_W], cnt_nxt};
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q       <= S_IDLE;
            wdata_q       <= '0;
            cnt_q         <= '0;
            wait_q        <= '0;
            err_q         <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            err_q         <= err_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_err     = rsp_valid & err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Directed bench for nor_flash_ctrl with a 1-cycle-latency NOR array model.
module tb_nor_flash_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    nor_flash_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mem_we(mem_we), .mem_re(mem_re), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_data_in;
        if (mem_re) mem_data_out <= mem[mem_address];
    end

`ifdef NOR_FLASH_PROGRAM_VERIFY_EN
    localparam int PG_LAT = 6;
    localparam bit VERIFY = 1'b1;
`else
    localparam int PG_LAT = 4;
    localparam bit VERIFY = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int         lat, nw, both;
    logic [7:0] wr_addr [0:31];
    logic [7:0] wr_data [0:31];
    logic [7:0] r_rdata;
    logic       r_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tally();
        if (mem_we && mem_re) both++;
        if (mem_we) begin
            if (nw < 32) begin
                wr_addr[nw] = mem_address;
                wr_data[nw] = mem_data_in;
            end
            nw++;
        end
    endtask

    // Called in cycle A+1; returns after the RESP cycle.
    task automatic wait_rsp();
        lat = 1; nw = 0; both = 0;
        while (!rsp_valid && lat < 40) begin
            tally();
            step();
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        tally();
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
        step();
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd);
        int guard = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        while (!cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
        step();
        cmd_valid = 1'b0;
        wait_rsp();
    endtask

    task automatic check_erase(input string tag, input logic [7:0] base);
        int bad = 0;
        int zero_wr = 0;
        for (int i = 0; i < 16; i++) begin
            if (wr_addr[i] !== 8'(base + i) || wr_data[i] !== 8'hFF) bad++;
            if (base != 8'h00 && wr_addr[i] == 8'h00) zero_wr++;
        end
        check({tag, "_nwrites"}, nw, 16);
        check({tag, "_seq"}, bad, 0);
        check({tag, "_nowrap"}, zero_wr, 0);
        check({tag, "_lat"}, lat, 17);
        check({tag, "_err"}, r_err, 0);
        check({tag, "_both"}, both, 0);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        do_cmd(2'b00, addr, 8'h00);
        check({tag, "_data"}, r_rdata, exp);
        check({tag, "_err"}, r_err, 0);
        check({tag, "_lat"}, lat, 3);
    endtask

    initial begin
        int rv_cnt, ready_hi;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_we, mem_re}, 2'b00);
        check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_data_in, 0);
        check("rst_rdata", rsp_rdata, 0);

        // Reset sampled at the start of A+5: only 0x10..0x13 have been erased.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 8'h13;
        step();
        cmd_valid = 1'b0;
        check("mid_first_wr", {mem_we, mem_address}, {1'b1, 8'h10});
        step(); step(); step();
        check("mid_fourth_wr", {mem_we, mem_address}, {1'b1, 8'h13});
        rst = 1'b1;
        step();
        check("mid_strobes", {mem_we, mem_re}, 2'b00);
        check("mid_busy", busy, 0);
        rst = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) rv_cnt++;
            step();
        end
        check("mid_no_rsp", rv_cnt, 0);
        read_expect("mid_rd10", 8'h10, 8'hFF);
        read_expect("mid_rd13", 8'h13, 8'hFF);
        read_expect("mid_rd14", 8'h14, 8'h14);
        read_expect("mid_rd1f", 8'h1F, 8'h1F);

        do_cmd(2'b11, 8'h05, 8'h00);
        check("rsv_lat", lat, 1);
        check("rsv_err", r_err, 1);
        check("rsv_rdata", r_rdata, 0);
        check("rsv_nowr", nw, 0);
        check("rsv_nore", mem_re, 0);

        do_cmd(2'b10, 8'h25, 8'h00);
        check_erase("er25", 8'h20);
        read_expect("er_rd20", 8'h20, 8'hFF);
        read_expect("er_rd2f", 8'h2F, 8'hFF);

        do_cmd(2'b01, 8'h21, 8'hAB);
        check("pg_ok_nw", nw, 1);
        check("pg_ok_wr", {wr_addr[0], wr_data[0]}, {8'h21, 8'hAB});
        check("pg_ok_err", r_err, 0);
        check("pg_ok_lat", lat, PG_LAT);
        read_expect("pg_ok_rd", 8'h21, 8'hAB);

        do_cmd(2'b01, 8'h21, 8'hCD);
        check("pg_bad_wr", wr_data[0], 8'h89);
        check("pg_bad_err", r_err, 1);
        check("pg_bad_lat", lat, PG_LAT);
        read_expect("pg_bad_rd", 8'h21, 8'h89);

        // A READ held during an erase must wait for the erase response.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 8'h45;
        step();
        cmd_op = 2'b00; cmd_addr = 8'h40;
        ready_hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (cmd_ready || !busy) ready_hi++;
            step();
        end
        check("busy_ready_low", ready_hi, 0);
        check("busy_er_rsp", {rsp_valid, cmd_ready}, 2'b10);
        step();
        check("busy_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        wait_rsp();
        check("busy_rd_data", r_rdata, 8'hFF);
        check("busy_rd_lat", lat, 3);

        do_cmd(2'b10, 8'hF7, 8'h00);
        check_erase("erF7", 8'hF0);
        check("top_00_intact", mem[0], 8'h00);

        do_cmd(2'b01, 8'hFF, 8'h34);
        check("top_pg_lat", lat, PG_LAT);
        check("top_pg_err", r_err, 0);
        check("top_pg_rdata", r_rdata, VERIFY ? 8'h34 : 8'hFF);
        check("top_pg_wr", {wr_addr[0], wr_data[0]}, {8'hFF, 8'h34});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nor_flash_ctrl.md
Name: nor_flash_ctrl

Overview:
- Host-side initiator that drives the nor_flash_memory port (clk, we, re, address, data_in, data_out).
- Accepts READ, PROGRAM and SECTOR_ERASE commands over a valid/ready handshake and sequences the memory strobes.
- Enforces NOR semantics on the memory array: erase sets bytes to 0xFF; program can only clear bits, implemented as read-modify-write.
- Sits between the system host logic and the flash array model.

Parameters:
ADDR_W, 8, address width (matches memory address).
DATA_W, 8, data width (matches memory data_in/data_out).
SECTOR_W, 4, log2 of sector size in words; default sector is 16 bytes.
READ_LAT, 1, cycles from the cycle mem_re is high to valid mem_data_out; legal range 1..3.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command request
cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid & cmd_ready
cmd_op  in  2  command: 00 READ, 01 PROGRAM, 10 SECTOR_ERASE, 11 reserved
cmd_addr  in  ADDR_W  target address; for erase, any address inside the sector
cmd_wdata  in  DATA_W  program data
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rdata  out  DATA_W  read data, valid with rsp_valid for READ
rsp_err  out  1  error flag, valid with rsp_valid
busy  out  1  high whenever state != IDLE
mem_we  out  1  memory write strobe (to we)
mem_re  out  1  memory read strobe (to re)
mem_address  out  ADDR_W  memory address
mem_data_in  out  DATA_W  memory write data
mem_data_out  in  DATA_W  memory read data

Behaviour:
- Reset values (synchronous, rst high at posedge):
  - State = IDLE.
  - mem_we, mem_re, rsp_valid, rsp_err, busy = 0.
  - mem_address, mem_data_in, rsp_rdata = 0.
  - cmd_ready = 1 in the cycle after reset releases.
- Reset mid-operation: the command is aborted and no response is issued. Strobes are 0 from the first cycle after the reset edge. A partially erased sector stays partially erased.
- Invariants:
  - mem_we and mem_re are never high in the same cycle.
  - Strobes are registered outputs.
  - Exactly one rsp_valid pulse per accepted command.
- States: IDLE, RD_ISSUE, RD_WAIT, PG_RD, PG_WAIT, PG_WR, ER_WR, (VF_RD, VF_WAIT when the optional feature is in), RESP.
- Accept cycle A is the cycle in which cmd_valid & cmd_ready. The command fields are latched at the end of A.
- READ:
  - A+1: RD_ISSUE, mem_re=1, mem_address=addr.
  - RD_WAIT for READ_LAT cycles, then capture mem_data_out.
  - RESP: rsp_valid=1 and rsp_rdata=captured value in cycle A+2+READ_LAT (A+3 for the default).
  - rsp_err=0.
- PROGRAM:
  - Read old value (PG_RD/PG_WAIT, same timing as READ).
  - PG_WR: mem_we=1 for one cycle, mem_data_in = old & wdata.
  - rsp_err=1 if (~old & wdata) != 0, i.e. an attempt to set a cleared bit. The AND result is still written.
  - RESP in the cycle after PG_WR. Default latency: rsp_valid in A+4.
- SECTOR_ERASE:
  - Base = cmd_addr with its low SECTOR_W bits zeroed.
  - ER_WR writes 0xFF (all-ones) to base+0 .. base+2^SECTOR_W-1, one per cycle, with mem_we high continuously.
  - Counter is SECTOR_W bits; the last write is at count all-ones. The address does not carry into the upper bits.
  - RESP in the cycle after the last write. rsp_valid at A+1+2^SECTOR_W (A+17 for the default); rsp_err=0.
- Reserved op 11: no memory access; RESP in A+1 with rsp_err=1, rsp_rdata=0.
- rsp_rdata holds its last value between responses. rsp_err is 0 whenever rsp_valid is 0.
- Top sector: erasing with cmd_addr=0xF7 writes 0xF0..0xFF. The address counter stops without wrapping to 0x00.
- cmd_valid while busy is ignored; the host holds its request until cmd_ready.

Optional Feature:
- Macro: NOR_FLASH_PROGRAM_VERIFY_EN.
- Defined:
  - After PG_WR, VF_RD/VF_WAIT re-read the same address.
  - rsp_err |= (readback != old & wdata).
  - rsp_rdata = readback.
  - PROGRAM latency grows by 1+READ_LAT (default rsp_valid at A+6).
- Undefined: VF states are absent. PROGRAM timing and rsp_rdata are as above; rsp_rdata holds its previous value.

Test Plan:
- Reset mid-erase:
  - Stimulus: rst pulse, then SECTOR_ERASE addr 0x13; assert rst at cycle A+5; then READ 0x10.
  - Required: strobes 0 the cycle after reset and no rsp_valid. Locations 0x10..0x13 read 0xFF; 0x14..0x1F are unchanged.
- Erase then read:
  - Stimulus: SECTOR_ERASE 0x25, then READ 0x20 and READ 0x2F.
  - Required: 16 consecutive mem_we cycles at 0x20..0x2F with data 0xFF; rsp at A+17. Both reads return 0xFF with rsp_err=0 at A+3.
- Legal program:
  - Stimulus: after erase, PROGRAM 0x21 with 0xAB, then READ 0x21.
  - Required: one mem_we with data 0xAB; rsp_err=0 at A+4. READ returns 0xAB.
- Illegal program:
  - Stimulus: PROGRAM 0x21 with 0xCD over existing 0xAB.
  - Required: written value 0x89; rsp_err=1. A following READ returns 0x89.
- Reserved op and busy:
  - Stimulus: cmd_op=11 addr 0x05; then issue a READ while an erase is busy.
  - Required: rsp_err=1 at A+1 with no mem_we/mem_re. cmd_ready=0 for the whole erase, and the READ is accepted only after the erase RESP.
- Top sector, verify build:
  - Stimulus: SECTOR_ERASE 0xF7; then PROGRAM 0xFF with 0x34 and NOR_FLASH_PROGRAM_VERIFY_EN defined.
  - Required: erase writes 0xF0..0xFF with no write to 0x00. PROGRAM gives rsp at A+6 with rsp_rdata=0x34 and rsp_err=0.
